// File: rtl/fast_counter_ud_if.sv
// ---------------------------------------------------------------------------
// fast_counter_ud_if
//   Command/status bundle for the fast_counter_ud up/down counter.
//   master : the block that issues commands and observes the count.
//   slave  : the counter itself.
//   Signals:
//     set        load set_val (wins over inc/dec)
//     set_val    value to load, WIDTH bits
//     inc / dec  count up / down by one (both high = hold)
//     q          registered count
//     q_is_zero  registered, q == 0
//     q_is_max   registered, q == all ones
//     bound      one-cycle pulse on inc at max / dec at zero
// ---------------------------------------------------------------------------
interface fast_counter_ud_if #(
    parameter int WIDTH = 16
);
    logic             set;
    logic [WIDTH-1:0] set_val;
    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] q;
    logic             q_is_zero;
    logic             q_is_max;
    logic             bound;

    modport master (
        output set, set_val, inc, dec,
        input  q, q_is_zero, q_is_max, bound
    );

    modport slave (
        input  set, set_val, inc, dec,
        output q, q_is_zero, q_is_max, bound
    );
endinterface

// File: rtl/fast_counter_ud.sv
// ---------------------------------------------------------------------------
// fast_counter_ud
//   Up/down counter whose low LSB_BITS bits live in pre-rotated bit-pattern
//   rings, so stepping the low part is a pure rotation with no adder. The
//   upper WIDTH-LSB_BITS bits use an ordinary incrementer/decrementer that
//   only steps when the carry ring (low == all ones) or borrow ring
//   (low == 0) says the low part is about to roll over.
//
//   Parameters:
//     WIDTH    total counter width (> LSB_BITS)
//     LSB_BITS ring-implemented low bits, 1..5
//     SATURATE 0 = wrap at both ends, 1 = hold at 0 and at all ones
//   Ports:
//     clk   rising-edge clock
//     nrst  asynchronous active-low reset
//     bus   fast_counter_ud_if.slave (set/set_val/inc/dec in,
//           q/q_is_zero/q_is_max/bound out, all outputs registered)
// ---------------------------------------------------------------------------
module fast_counter_ud #(
    parameter int WIDTH    = 16,
    parameter int LSB_BITS = 4,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              nrst,
    fast_counter_ud_if.slave  bus
);

    localparam int RING_LEN = 2 ** LSB_BITS;
    localparam int MSB_W    = WIDTH - LSB_BITS;
    localparam bit SAT_EN   = (SATURATE != 0);

    // Reset pattern of the carry ring: only the position for low == all ones.
    localparam logic [RING_LEN-1:0] CARRY_BASE  = {1'b1, {(RING_LEN-1){1'b0}}};
    // Reset pattern of the borrow ring: only the position for low == 0.
    localparam logic [RING_LEN-1:0] BORROW_BASE = {{(RING_LEN-1){1'b0}}, 1'b1};

    // Reset pattern of data ring k: position p holds bit k of value p.
    function automatic logic [RING_LEN-1:0] base_ring(input int k);
        logic [RING_LEN-1:0] r;
        r = {RING_LEN{1'b0}};
        for (int p = 0; p < RING_LEN; p++) begin
            r[p] = 1'((p >> k) & 1);
        end
        return r;
    endfunction

    // Pattern as seen when the low value is amt: element p = base[p + amt].
    function automatic logic [RING_LEN-1:0] rotate_to(
        input logic [RING_LEN-1:0] base,
        input logic [LSB_BITS-1:0] amt
    );
        logic [RING_LEN-1:0] r;
        logic [LSB_BITS-1:0] idx;
        r = {RING_LEN{1'b0}};
        for (int p = 0; p < RING_LEN; p++) begin
            idx  = LSB_BITS'(p) + amt;
            r[p] = base[idx];
        end
        return r;
    endfunction

    // One step toward increasing value: element p takes old element p+1.
    function automatic logic [RING_LEN-1:0] rot_up(input logic [RING_LEN-1:0] x);
        return {x[0], x[RING_LEN-1:1]};
    endfunction

    // One step toward decreasing value: element p takes old element p-1.
    function automatic logic [RING_LEN-1:0] rot_down(input logic [RING_LEN-1:0] x);
        return {x[RING_LEN-2:0], x[RING_LEN-1]};
    endfunction

    logic [LSB_BITS-1:0][RING_LEN-1:0] ring_r,   ring_s;
    logic [RING_LEN-1:0]               carry_r,  carry_s;
    logic [RING_LEN-1:0]               borrow_r, borrow_s;
    logic [MSB_W-1:0]                  msb_r,    msb_s;
    logic                              zero_r,   zero_s;
    logic                              max_r,    max_s;
    logic                              bound_r,  bound_s;
    logic                              at_max_s, at_zero_s;
    logic                              do_inc_s, do_dec_s;
    logic [LSB_BITS-1:0]               low_q_s;

    // Next-state selection: set, then a lone inc or dec, otherwise hold.
    always_comb begin
        ring_s    = ring_r;
        carry_s   = carry_r;
        borrow_s  = borrow_r;
        msb_s     = msb_r;
        bound_s   = 1'b0;
        at_max_s  = carry_r[0]  & (&msb_r);
        at_zero_s = borrow_r[0] & ~(|msb_r);
        do_inc_s  = bus.inc & ~bus.dec;
        do_dec_s  = bus.dec & ~bus.inc;

        if (bus.set) begin
            for (int k = 0; k < LSB_BITS; k++) begin
                ring_s[k] = rotate_to(base_ring(k), bus.set_val[LSB_BITS-1:0]);
            end
            carry_s  = rotate_to(CARRY_BASE,  bus.set_val[LSB_BITS-1:0]);
            borrow_s = rotate_to(BORROW_BASE, bus.set_val[LSB_BITS-1:0]);
            msb_s    = bus.set_val[WIDTH-1:LSB_BITS];
        end else if (do_inc_s) begin
            bound_s = at_max_s;
            if (at_max_s && SAT_EN) begin
                msb_s = msb_r;
            end else begin
                for (int k = 0; k < LSB_BITS; k++) begin
                    ring_s[k] = rot_up(ring_r[k]);
                end
                carry_s  = rot_up(carry_r);
                borrow_s = rot_up(borrow_r);
                // Upper field only moves when the low part rolls from all ones.
                if (carry_r[0]) begin
                    msb_s = msb_r + MSB_W'(1);
                end else begin
                    msb_s = msb_r;
                end
            end
        end else if (do_dec_s) begin
            bound_s = at_zero_s;
            if (at_zero_s && SAT_EN) begin
                msb_s = msb_r;
            end else begin
                for (int k = 0; k < LSB_BITS; k++) begin
                    ring_s[k] = rot_down(ring_r[k]);
                end
                carry_s  = rot_down(carry_r);
                borrow_s = rot_down(borrow_r);
                // Upper field only moves when the low part rolls from zero.
                if (borrow_r[0]) begin
                    msb_s = msb_r - MSB_W'(1);
                end else begin
                    msb_s = msb_r;
                end
            end
        end else begin
            msb_s = msb_r;
        end

        // Flags derive from next state so they are registered alongside q.
        zero_s = borrow_s[0] & (msb_s == {MSB_W{1'b0}});
        max_s  = carry_s[0]  & (&msb_s);
    end

    // State and flag registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < LSB_BITS; k++) begin
                ring_r[k] <= base_ring(k);
            end
            carry_r  <= CARRY_BASE;
            borrow_r <= BORROW_BASE;
            msb_r    <= {MSB_W{1'b0}};
            zero_r   <= 1'b1;
            max_r    <= 1'b0;
            bound_r  <= 1'b0;
        end else begin
            ring_r   <= ring_s;
            carry_r  <= carry_s;
            borrow_r <= borrow_s;
            msb_r    <= msb_s;
            zero_r   <= zero_s;
            max_r    <= max_s;
            bound_r  <= bound_s;
        end
    end

    // Low bits of q come straight from element 0 of each data ring.
    always_comb begin
        low_q_s = {LSB_BITS{1'b0}};
        for (int k = 0; k < LSB_BITS; k++) begin
            low_q_s[k] = ring_r[k][0];
        end
    end

    assign bus.q         = {msb_r, low_q_s};
    assign bus.q_is_zero = zero_r;
    assign bus.q_is_max  = max_r;
    assign bus.bound     = bound_r;

endmodule

// File: doc/fast_counter_ud.md
Name: fast_counter_ud

Overview:
- Parametrised up/down successor to the team's fast down-counter.
- The low LSB_BITS bits are held as pre-rotated bit-pattern rings, so the low half needs no adder.
- The upper bits use a plain incrementer/decrementer that steps only on ring carry/borrow, so the critical path spans only WIDTH-LSB_BITS bits.
- Adds: count-up, wrap or saturate mode, registered zero/max flags and a boundary pulse. Used for timeouts, credit counters and pacing in timing-critical paths.

Parameters:
- WIDTH, 16: total counter width; must be > LSB_BITS.
- LSB_BITS, 4: number of ring-implemented low bits; legal range 1..5; ring length is 2**LSB_BITS.
- SATURATE, 0: 0 = wrap-around at both ends; 1 = hold at 0 and at 2**WIDTH-1.

Ports:
- clk  input  1  clock, rising-edge.
- nrst  input  1  asynchronous active-low reset.
- set  input  1  load set_val; highest priority after reset.
- set_val  input  WIDTH  value to load.
- inc  input  1  count up by one.
- dec  input  1  count down by one.
- q  output  WIDTH  current count, registered.
- q_is_zero  output  1  registered; high iff q == 0.
- q_is_max  output  1  registered; high iff q == 2**WIDTH-1.
- bound  output  1  one-cycle pulse: an inc was applied at max, or a dec was applied at 0.

Behaviour:
- Reset (nrst low, asynchronous):
  - q = 0; rings aligned to low value 0.
  - q_is_zero = 1, q_is_max = 0, bound = 0.
  - Any operation in flight is discarded.
  - The first operation is taken at the first rising edge after nrst deasserts.
- Operation priority per cycle:
  - set.
  - Then inc xor dec.
  - inc and dec both high with set low: hold. No count change; bound = 0.
- Storage of the low bits:
  - One ring per bit k (0..LSB_BITS-1), 2**LSB_BITS bits long. Position p of ring k holds bit k of value p.
  - Two additional one-hot rings: carry ring (marks low == all-ones) and borrow ring (marks low == 0).
  - Element 0 of each ring is the current value. q[LSB_BITS-1:0] is taken directly from ring element 0.
- inc: all rings rotate toward increasing value. The MSB field increments in the same cycle iff the carry-ring element 0 is set.
- dec: all rings rotate the opposite way. The MSB field decrements iff the borrow-ring element 0 is set.
- set: each ring is loaded pre-rotated by set_val[LSB_BITS-1:0]; the MSB field gets set_val[WIDTH-1:LSB_BITS]. Result is visible on q in the cycle after the edge.
- Latency: every operation is visible on q and the flags one cycle after the sampling edge. No combinational path from inputs to outputs.
- Flags:
  - q_is_zero and q_is_max are computed from next-state and registered together with q, so they always match q.
  - Each flag is the MSB-field compare ANDed with the borrow-ring bit (zero) or carry-ring bit (max).
- Boundaries, SATURATE=0:
  - inc at max: q becomes 0, bound pulses.
  - dec at 0: q becomes max, bound pulses.
- Boundaries, SATURATE=1:
  - inc at max and dec at 0 leave q and all rings unchanged; bound still pulses.
- bound:
  - Registered, high for exactly one cycle per boundary operation.
  - Repeats every cycle while the boundary operation is held.
  - Never asserted by set or by an inc+dec collision.
- set with set_val equal to the current q is legal; state is unchanged and bound stays 0.
- Arithmetic is unsigned modulo 2**WIDTH. The ring state must always be a rotation of the reset pattern.

Test Plan:
- Reset mid-count: WIDTH=8, LSB_BITS=4. Count to 0x37, pull nrst low between edges -> q = 0x00 and q_is_zero = 1 immediately; first inc after release -> 0x01.
- Ring carry: set 0x0E, then inc x3 -> q = 0x0F, 0x10, 0x11 on consecutive cycles; MSB field steps exactly once.
- Ring borrow: set 0x20, dec x2 -> q = 0x1F, 0x1E; q_is_zero stays 0 throughout.
- Wrap mode: set 0xFF (q_is_max = 1), inc -> q = 0x00, bound = 1 for one cycle, q_is_zero = 1. Then dec -> q = 0xFF, bound = 1.
- Saturate mode (SATURATE=1): set 0x01, dec x3 -> q = 0x00, 0x00, 0x00; bound = 0, 1, 1.
- Priority and collision: set with set_val=0x5A plus inc and dec all high -> q = 0x5A. Then inc and dec together -> q stays 0x5A, bound = 0. Randomised 10k-cycle run against a reference model: q and flags match every cycle.
